seq_interval_timer: RTL and testbench
=====================================

Name: seq_interval_timer

Overview:
- Timing responder for the display-sequencing FSM. The FSM drives initCount and countVal; this block returns contBETval.
- Divides the system clock into a slow tick and counts ticks from 0.
- Flags when the tick count is greater than or equal to the requested value.
- Restarts itself whenever the request is withdrawn or the requested value changes, so the FSM can chain phases (6 then 3) without dropping initCount.

Parameters:
- TICK_DIV, 50000000, clock cycles per tick (1 s at 50 MHz); legal range >= 2.
- DIV_W, 26, prescaler width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- initCount  in  1  1 = run timer; 0 = hold cleared.
- countVal  in  3  requested tick count (0..7).
- contBETval  out  1  combinational; 1 when running and count >= latched value.
- count  out  3  current tick count, for display/debug.
- tick  out  1  registered one-cycle pulse on each prescaler wrap.
- pause  in  1  present only with SEQ_TIMER_PAUSE_EN; 1 = freeze.

Behaviour:
- Internal registers: pre[DIV_W-1:0], cnt[2:0], val_q[2:0], tick_q.
- Reset (reset=0, async): pre=0, cnt=0, val_q=0, tick_q=0. Hence count=0, tick=0, contBETval=0.
- restart = !initCount || (countVal != val_q), evaluated combinationally.
- Clock edge with restart=1: pre<=0, cnt<=0, tick_q<=0, val_q<=countVal.
- Clock edge with restart=0 (running):
  - If pre==TICK_DIV-1: pre<=0, tick_q<=1, cnt<=cnt+1, saturating at 7 (no wrap).
  - Otherwise: pre<=pre+1, tick_q<=0.
- contBETval = initCount && (countVal == val_q) && (cnt >= val_q).
  - Combinational, so in the first cycle after the FSM changes countVal (e.g. 6 to 3) the output is already 0.
  - A stale "done" must never carry into the next phase.
- Latency:
  - First tick arrives TICK_DIV cycles after the first running cycle.
  - contBETval rises in the cycle after the edge where cnt reaches val_q, i.e. val_q*TICK_DIV cycles after the run starts.
- countVal=0: contBETval=1 from the first running cycle (cnt=0 >= 0).
- After done: contBETval stays 1 while initCount=1 and countVal is unchanged. cnt keeps counting to 7, then holds.
- initCount dropping mid-count: cleared on the next edge; contBETval drops immediately (combinational).
- countVal changing while running: treated as a new request; full restart with a fresh prescaler (no partial tick credited).
- Simultaneous countVal change and prescaler wrap: restart wins; no tick pulse, cnt=0.
- Reset asserted mid-count: all state cleared asynchronously. After release, the timer waits one cycle in restart if countVal != 0 (val_q was reset to 0).

Optional Feature:
- Macro: SEQ_TIMER_PAUSE_EN.
- Defined:
  - Adds the pause input.
  - pause=1 with restart=0 holds pre, cnt and val_q, and forces tick_q<=0.
  - contBETval still evaluates normally.
  - restart overrides pause.
- Undefined: no pause port; behaviour exactly as above.

Test Plan (TICK_DIV=4):
- Reset low, then high, with initCount=0 -> count=0, tick=0, contBETval=0 throughout.
- initCount=1, countVal=6 -> tick pulses every 4 cycles; contBETval=1 exactly 24 cycles after the first running cycle, then stays 1.
- Hold initCount=1 while done; switch countVal 6->3 -> contBETval=0 in the same cycle; count=0 next edge; contBETval=1 again 12 cycles later.
- initCount=1, countVal=0 -> contBETval=1 in the first cycle after val_q latches 0.
- Drop initCount at cnt=2, raise it 2 cycles later with countVal=3 -> count restarts from 0; done after 12 more cycles.
- With SEQ_TIMER_PAUSE_EN, countVal=3: pause=1 for 5 cycles mid-count -> done delayed by exactly 5 cycles (17 total); no tick during pause.

Source files
------------

// File: rtl/seq_interval_timer.sv
// Tick-based interval timer for the display-sequencing FSM: counts prescaled ticks
// and flags when the requested count is reached. Define SEQ_TIMER_PAUSE_EN for the pause input.
module seq_interval_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       initCount,
    input  logic [2:0] countVal,
`ifdef SEQ_TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic       contBETval,
    output logic [2:0] count,
    output logic       tick
);

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] pre_q, pre_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       val_q, val_d;
    logic             tick_q, tick_d;
    logic             restart;
    logic             paused;

`ifdef SEQ_TIMER_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    // Any change of request (or withdrawal) starts a fresh phase, so no stale done survives.
    assign restart = !initCount || (countVal != val_q);

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        val_d  = val_q;
        tick_d = 1'b0;
        if (restart) begin
            pre_d = '0;
            cnt_d = 3'd0;
            val_d = countVal;
        end else if (paused) begin
            tick_d = 1'b0;
        end else if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
            cnt_d  = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;
        end else begin
            pre_d = pre_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            cnt_q  <= 3'd0;
            val_q  <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            val_q  <= val_d;
            tick_q <= tick_d;
        end
    end

    assign contBETval = initCount && (countVal == val_q) && (cnt_q >= val_q);
    assign count      = cnt_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_seq_interval_timer.sv
// Scoreboard bench for seq_interval_timer (TICK_DIV=4): a cycle-level reference model
// queues expected outputs, a negedge monitor compares them against the DUT.
module tb_seq_interval_timer;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       initCount = 1'b0;
    logic [2:0] countVal = 3'd0;
    logic       pause = 1'b0;
    logic       contBETval;
    logic [2:0] count;
    logic       tick;

    seq_interval_timer #(.TICK_DIV(TD), .DIV_W(3)) dut (
        .clock      (clock),
        .reset      (reset),
        .initCount  (initCount),
        .countVal   (countVal),
`ifdef SEQ_TIMER_PAUSE_EN
        .pause      (pause),
`endif
        .contBETval (contBETval),
        .count      (count),
        .tick       (tick)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] cnt;
        logic       tck;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: requested value and number of unpaused running edges in this phase.
    int   m_val = 0;
    int   m_runs = 0;
    bit   m_tick = 1'b0;

    function automatic bit pause_eff(input logic p);
`ifdef SEQ_TIMER_PAUSE_EN
        return p;
`else
        return 1'b0;
`endif
    endfunction

    task automatic cyc(input bit rn, input bit ini, input int v, input bit p);
        int c;
        exp_t e;
        @(posedge clock);
        if (reset) begin
            if (!initCount || int'(countVal) != m_val) begin
                m_val  = int'(countVal);
                m_runs = 0;
                m_tick = 1'b0;
            end else if (pause_eff(pause)) begin
                m_tick = 1'b0;
            end else begin
                m_runs = m_runs + 1;
                m_tick = (m_runs % TD) == 0;
            end
        end
        #1;
        reset     = rn;
        initCount = ini;
        countVal  = 3'(v);
        pause     = p;
        if (!rn) begin
            m_val = 0; m_runs = 0; m_tick = 1'b0;
        end
        c = m_runs / TD;
        if (c > 7) c = 7;
        e.cnt  = 3'(c);
        e.tck  = m_tick;
        e.done = ini && (v == m_val) && (c >= m_val);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input bit ini, input int v, input bit p);
        for (int i = 0; i < n; i++) cyc(1'b1, ini, v, p);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors = vectors + 1;
            if (count !== e.cnt || tick !== e.tck || contBETval !== e.done) begin
                miscompares = miscompares + 1;
                $display("FAIL vec %0d @%0t: got count=%0d tick=%b contBETval=%b, expected count=%0d tick=%b contBETval=%b",
                         vectors, $time, count, tick, contBETval, e.cnt, e.tck, e.done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int v;
        bit ini, p;
        // Reset held, then released with the request withdrawn.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 1'b0);
        run(4, 1'b0, 0, 1'b0);
        // Phase of 6 ticks, held well past done.
        run(32, 1'b1, 6, 1'b0);
        // Chain straight into a 3-tick phase.
        run(16, 1'b1, 3, 1'b0);
        // Zero request is done immediately.
        run(4, 1'b1, 0, 1'b0);
        // Withdraw mid-count, re-request.
        run(9, 1'b1, 3, 1'b0);
        run(2, 1'b0, 3, 1'b0);
        run(15, 1'b1, 3, 1'b0);
        // Asynchronous reset mid-count.
        run(7, 1'b1, 5, 1'b0);
        cyc(1'b0, 1'b1, 5, 1'b0);
        cyc(1'b0, 1'b1, 5, 1'b0);
        run(25, 1'b1, 5, 1'b0);
        // Pause mid-count (no effect when the pause port is not built).
        run(2, 1'b0, 3, 1'b0);
        run(6, 1'b1, 3, 1'b0);
        run(5, 1'b1, 3, 1'b1);
        run(12, 1'b1, 3, 1'b0);
        // Randomised phases.
        v = 2; ini = 1'b1; p = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 19) == 0) v = int'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) ini = ~ini;
            p = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) cyc(1'b0, ini, v, p);
            else cyc(1'b1, ini, v, p);
        end
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() > 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
